// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write arbiter.
//   DATA_W   - write data width
//   ADDR_W   - register address width
//   NUM_REGS - number of registers tracked by the pending scoreboard
//   IDX_W    - scoreboard index width (low address bits)
//   arb_sel_t - round-robin priority pointer (SEL_A / SEL_B)
package regfile_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 8;
  localparam int unsigned IDX_W    = 3;

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } arb_sel_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-way round-robin grant decision.
// Ports:
//   req[1:0] in  - request vector, bit 0 = A, bit 1 = B
//   ptr      in  - priority pointer, side that wins when both request
//   hold     in  - suppresses all grants
//   gnt[1:0] out - one-hot (or zero) grant vector
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  input  logic       hold,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    if (!hold) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (arb_sel_t'(ptr) == SEL_A) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbitration of two register-file write
// requesters (A = ALU, B = load) onto a single registered write port, with an
// optional pending-write scoreboard for hazard lookup.
// Ports:
//   CLK, RST_N                 - clock, synchronous active-low reset
//   VALID_x/ADDR_x/DATA_x      - write requests from A and B
//   READY_A, READY_B           - combinational grants (handshake = VALID & READY)
//   HOLD                       - pipeline freeze, blocks new grants
//   WE3, A3, WD3               - registered register-file write port (1-cycle latency)
//   RSV_VALID, RSV_ADDR        - reserve a destination register (scoreboard)
//   A1, A2                     - read addresses for hazard lookup
//   BUSY1, BUSY2               - pending write to A1 / A2
// Build option: define REGFILE_ARB_SCOREBOARD_EN to enable the pending
// scoreboard; otherwise BUSY1/BUSY2 are tied to 0 and RSV_* / A1 / A2 are ignored.
module regfile_write_arbiter
  import regfile_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              VALID_A,
  input  logic              VALID_B,
  input  logic [ADDR_W-1:0] ADDR_A,
  input  logic [ADDR_W-1:0] ADDR_B,
  input  logic [DATA_W-1:0] DATA_A,
  input  logic [DATA_W-1:0] DATA_B,
  output logic              READY_A,
  output logic              READY_B,
  input  logic              HOLD,
  output logic              WE3,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  input  logic              RSV_VALID,
  input  logic [ADDR_W-1:0] RSV_ADDR,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic              BUSY1,
  output logic              BUSY2
);

  arb_sel_t   ptr_q;
  logic [1:0] gnt;

  // Reset is folded into hold so no grant is visible while RST_N is low.
  rr_arbiter2 u_arb (
    .req  ({VALID_B, VALID_A}),
    .ptr  (ptr_q),
    .hold (HOLD | ~RST_N),
    .gnt  (gnt)
  );

  assign READY_A = gnt[0];
  assign READY_B = gnt[1];

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      WE3   <= 1'b0;
      A3    <= '0;
      WD3   <= '0;
      ptr_q <= SEL_A;
    end else begin
      WE3 <= |gnt;
      if (gnt[0]) begin
        A3    <= ADDR_A;
        WD3   <= DATA_A;
        ptr_q <= SEL_B;
      end else if (gnt[1]) begin
        A3    <= ADDR_B;
        WD3   <= DATA_B;
        ptr_q <= SEL_A;
      end
    end
  end

`ifdef REGFILE_ARB_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Clear is applied before set so a same-index reserve wins.
  always_comb begin
    pending_d = pending_q;
    if (WE3)       pending_d[A3[IDX_W-1:0]]       = 1'b0;
    if (RSV_VALID) pending_d[RSV_ADDR[IDX_W-1:0]] = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign BUSY1 = pending_q[A1[IDX_W-1:0]];
  assign BUSY2 = pending_q[A2[IDX_W-1:0]];
`else
  logic unused_sb;
  assign unused_sb = ^{RSV_VALID, RSV_ADDR, A1, A2};
  assign BUSY1 = 1'b0;
  assign BUSY2 = 1'b0;
`endif

endmodule
